// File: rtl/img_stream_reader.sv
// Streams an img_w x img_h frame of pixels from DRAM into a small output FIFO,
// tagging each pixel with end-of-row / end-of-frame flags.
module img_stream_reader #(
    parameter int A_WIDTH    = 20,
    parameter int D_WIDTH    = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [A_WIDTH-1:0] base_addr,
    input  logic [10:0]        img_w,
    input  logic [10:0]        img_h,
    output logic               busy,
    output logic               done,
    output logic               ren,
    output logic [A_WIDTH-1:0] raddr,
    input  logic [D_WIDTH-1:0] rdata,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [D_WIDTH-1:0] out_data,
    output logic               out_eol,
    output logic               out_last
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam int EW = D_WIDTH + 2;
    localparam logic [CW:0] L_DEPTH = (CW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

    state_t             r_state;
    state_t             w_next;
    logic [A_WIDTH-1:0] r_raddr;
    logic [10:0]        r_w;
    logic [10:0]        r_h;
    logic [10:0]        r_col;
    logic [10:0]        r_row;
    logic               r_inflight;
    logic               r_infl_eol;
    logic               r_infl_last;
    logic               r_done;
    logic [EW-1:0]      r_mem [FIFO_DEPTH];
    logic [PW-1:0]      r_wptr;
    logic [PW-1:0]      r_rptr;
    logic [CW-1:0]      r_count;

    logic               w_start_ok;
    logic               w_start_empty;
    logic               w_ren;
    logic               w_busy;
    logic               w_eol;
    logic               w_last;
    logic               w_push;
    logic               w_pop;
    logic               w_empty;
    logic               w_last_pop;
    logic [EW-1:0]      w_head;
    logic [CW:0]        w_occ;

    assign w_start_ok    = start && (img_w != '0) && (img_h != '0);
    assign w_start_empty = start && ((img_w == '0) || (img_h == '0));
    assign w_empty       = (r_count == '0);
    assign w_head        = r_mem[r_rptr];
    assign w_push        = r_inflight;
    assign w_pop         = !w_empty && out_ready;
    assign w_last_pop    = w_pop && w_head[0];
    // Reads already in flight reserve a FIFO slot, so the buffer can never overflow
    assign w_occ         = {1'b0, r_count} + {{CW{1'b0}}, r_inflight};
    assign w_eol         = (r_col == r_w - 11'd1);
    assign w_last        = w_eol && (r_row == r_h - 11'd1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        w_ren  = 1'b0;
        w_busy = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_start_ok) w_next = S_RUN;
            end
            S_RUN: begin
                w_busy = 1'b1;
                w_ren  = (w_occ < L_DEPTH);
                if (w_ren && w_last) w_next = S_DRAIN;
            end
            S_DRAIN: begin
                w_busy = 1'b1;
                if (w_last_pop) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_raddr     <= '0;
            r_w         <= '0;
            r_h         <= '0;
            r_col       <= '0;
            r_row       <= '0;
            r_inflight  <= 1'b0;
            r_infl_eol  <= 1'b0;
            r_infl_last <= 1'b0;
            r_done      <= 1'b0;
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_count     <= '0;
            // Storage is cleared too so the head (out_data/out_eol/out_last) reads 0
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
        end else begin
            r_done     <= ((r_state == S_IDLE) && w_start_empty) ||
                          ((r_state == S_DRAIN) && w_last_pop);
            r_inflight <= w_ren;
            if (w_ren) begin
                r_infl_eol  <= w_eol;
                r_infl_last <= w_last;
            end

            if ((r_state == S_IDLE) && w_start_ok) begin
                r_raddr <= base_addr;
                r_w     <= img_w;
                r_h     <= img_h;
                r_col   <= '0;
                r_row   <= '0;
            end else if (w_ren) begin
                r_raddr <= r_raddr + 1'b1;
                if (w_eol) begin
                    r_col <= '0;
                    r_row <= r_row + 11'd1;
                end else begin
                    r_col <= r_col + 11'd1;
                end
            end

            if (w_push) begin
                r_mem[r_wptr] <= {rdata, r_infl_eol, r_infl_last};
                r_wptr        <= r_wptr + 1'b1;
            end
            if (w_pop) r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign busy      = w_busy;
    assign done      = r_done;
    assign ren       = w_ren;
    assign raddr     = r_raddr;
    assign out_valid = !w_empty;
    assign out_data  = w_head[EW-1:2];
    assign out_eol   = w_head[1];
    assign out_last  = w_head[0];

endmodule

// File: tb/tb_img_stream_reader.sv
// Directed bench for img_stream_reader: frame table plus hand-written sequences
// for back-pressure, zero-size frames, mid-frame reset and ignored start.
module tb_img_stream_reader;

    localparam int AW = 20;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [10:0]   img_w;
    logic [10:0]   img_h;
    logic          busy;
    logic          done;
    logic          ren;
    logic [AW-1:0] raddr;
    logic [DW-1:0] rdata;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          out_eol;
    logic          out_last;

    img_stream_reader #(.A_WIDTH(AW), .D_WIDTH(DW), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
        .img_w(img_w), .img_h(img_h), .busy(busy), .done(done), .ren(ren),
        .raddr(raddr), .rdata(rdata), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_eol(out_eol), .out_last(out_last)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DW-1:0] pix_of(input logic [AW-1:0] a);
        return a[7:0] ^ 8'hA5;
    endfunction

    // DRAM model: data valid the cycle after ren
    initial rdata = '0;
    always @(posedge clk) if (ren) rdata <= pix_of(raddr);

    logic [AW-1:0] ren_q[$];
    int            ren_c[$];
    logic [DW+1:0] pix_q[$];
    int            pix_c[$];
    int            done_c[$];

    always @(negedge clk) begin
        if (ren) begin
            ren_q.push_back(raddr);
            ren_c.push_back(cyc);
        end
        if (out_valid && out_ready) begin
            pix_q.push_back({out_data, out_eol, out_last});
            pix_c.push_back(cyc);
        end
        if (done) done_c.push_back(cyc);
    end

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic pulse_start(input logic [AW-1:0] b, input logic [10:0] w, input logic [10:0] h,
                               output int k);
        @(posedge clk);
        #1;
        ren_q.delete(); ren_c.delete(); pix_q.delete(); pix_c.delete(); done_c.delete();
        base_addr = b;
        img_w     = w;
        img_h     = h;
        start     = 1'b1;
        k         = cyc;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
        check({tag, "_done_seen"}, ok, 1'b1);
        @(posedge clk);
        #1;
    endtask

    task automatic check_frame(input string tag, input logic [AW-1:0] base, input int w,
                               input int n, input logic [AW-1:0] last_addr, input int k,
                               input bit timing);
        int            bad;
        logic [AW-1:0] ea;
        logic [DW+1:0] ep;
        check({tag, "_ren_count"}, ren_q.size(), n);
        if (ren_q.size() > 0) begin
            check({tag, "_first_addr"}, ren_q[0], base);
            check({tag, "_last_addr"}, ren_q[ren_q.size()-1], last_addr);
        end
        bad = 0;
        for (int i = 0; i < ren_q.size(); i++) begin
            ea = base + i[AW-1:0];
            if (ren_q[i] !== ea) bad++;
        end
        check({tag, "_addr_seq_errs"}, bad, 0);
        check({tag, "_pix_count"}, pix_q.size(), n);
        bad = 0;
        for (int i = 0; i < pix_q.size(); i++) begin
            ea = base + i[AW-1:0];
            ep = {pix_of(ea), (i % w) == (w - 1), i == (n - 1)};
            if (pix_q[i] !== ep) bad++;
        end
        check({tag, "_pix_seq_errs"}, bad, 0);
        check({tag, "_done_pulses"}, done_c.size(), 1);
        if (done_c.size() == 1 && pix_c.size() > 0)
            check({tag, "_done_cycle"}, done_c[0], pix_c[pix_c.size()-1] + 1);
        if (timing && ren_c.size() > 0 && pix_c.size() > 0) begin
            check({tag, "_first_ren_cyc"}, ren_c[0], k + 1);
            check({tag, "_ren_contig"}, ren_c[ren_c.size()-1] - ren_c[0], ren_c.size() - 1);
            check({tag, "_first_pix_cyc"}, pix_c[0], k + 3);
            check({tag, "_pix_contig"}, pix_c[pix_c.size()-1] - pix_c[0], pix_c.size() - 1);
        end
    endtask

    typedef struct {
        logic [AW-1:0] base;
        logic [10:0]   w;
        logic [10:0]   h;
        int            n;
        logic [AW-1:0] last_addr;
    } fvec_t;

    fvec_t tbl[5];

    initial begin
        int k;
        int bad;

        tbl[0] = '{base: 20'h00000, w: 11'd4, h: 11'd2, n: 8, last_addr: 20'h00007};
        tbl[1] = '{base: 20'hFFFFE, w: 11'd4, h: 11'd1, n: 4, last_addr: 20'h00001};
        tbl[2] = '{base: 20'h12345, w: 11'd1, h: 11'd3, n: 3, last_addr: 20'h12347};
        tbl[3] = '{base: 20'h00100, w: 11'd5, h: 11'd1, n: 5, last_addr: 20'h00104};
        tbl[4] = '{base: 20'h0ABCD, w: 11'd3, h: 11'd3, n: 9, last_addr: 20'h0ABD5};

        rst       = 1'b1;
        start     = 1'b0;
        base_addr = '0;
        img_w     = '0;
        img_h     = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_ren", ren, 1'b0);
        check("rst_raddr", raddr, 20'h0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_data", out_data, 8'h00);
        check("rst_out_eol", out_eol, 1'b0);
        check("rst_out_last", out_last, 1'b0);

        // Frame table, consumer always ready
        for (int t = 0; t < 5; t++) begin
            pulse_start(tbl[t].base, tbl[t].w, tbl[t].h, k);
            wait_done($sformatf("frame%0d", t), 200);
            check_frame($sformatf("frame%0d", t), tbl[t].base, int'(tbl[t].w), tbl[t].n,
                        tbl[t].last_addr, k, 1'b1);
        end

        // Back-pressure: only FIFO_DEPTH reads issue while the consumer stalls
        out_ready = 1'b0;
        pulse_start(20'h00200, 11'd8, 11'd1, k);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid && out_data !== pix_of(20'h00200)) bad++;
        end
        check("bp_ren_count", ren_q.size(), 4);
        if (ren_q.size() > 0) check("bp_last_addr", ren_q[ren_q.size()-1], 20'h00203);
        check("bp_ren_now", ren, 1'b0);
        check("bp_valid", out_valid, 1'b1);
        check("bp_head_data", out_data, pix_of(20'h00200));
        check("bp_head_stable_errs", bad, 0);
        check("bp_busy", busy, 1'b1);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        wait_done("bp", 200);
        check_frame("bp", 20'h00200, 8, 8, 20'h00207, k, 1'b0);

        // Zero-width frame: immediate done, no reads
        pulse_start(20'h00000, 11'd0, 11'd5, k);
        @(negedge clk);
        check("zero_done", done, 1'b1);
        check("zero_busy", busy, 1'b0);
        repeat (3) @(negedge clk);
        check("zero_ren_count", ren_q.size(), 0);
        check("zero_done_pulses", done_c.size(), 1);
        if (done_c.size() > 0) check("zero_done_cyc", done_c[0], k + 1);
        check("zero_busy_after", busy, 1'b0);

        // Reset three read cycles into a large frame
        pulse_start(20'h00040, 11'd16, 11'd16, k);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("abort_pre_reads", ren_q.size(), 3);
        check("abort_ren", ren, 1'b0);
        check("abort_valid", out_valid, 1'b0);
        check("abort_busy", busy, 1'b0);
        check("abort_raddr", raddr, 20'h0);
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (out_valid || ren || done || busy) bad++;
        end
        check("abort_quiet_errs", bad, 0);
        check("abort_no_done", done_c.size(), 0);
        pulse_start(20'h00300, 11'd2, 11'd1, k);
        wait_done("restart", 200);
        check_frame("restart", 20'h00300, 2, 2, 20'h00301, k, 1'b1);

        // start while busy must be ignored
        pulse_start(20'h00500, 11'd3, 11'd2, k);
        base_addr = 20'h00900;
        img_w     = 11'd1;
        img_h     = 11'd1;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done("ignore", 200);
        check_frame("ignore", 20'h00500, 3, 6, 20'h00505, k, 1'b1);
        repeat (3) @(negedge clk);
        check("ignore_no_extra_ren", ren_q.size(), 6);
        check("ignore_idle", busy, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/img_stream_reader.md
IMG_STREAM_READER -- requirements
Module: img_stream_reader

Interface
REQ-001 Parameter: A_WIDTH, default 20, DRAM address width.
REQ-002 Parameter: D_WIDTH, default 8, pixel width.
REQ-003 Parameter: FIFO_DEPTH, default 4, output buffer entries; power of two, minimum 2.
REQ-004 Clocking SHALL be as follows: single clock `clk`; reset `rst` is synchronous and active-high.
REQ-005 Port list SHALL be (name, direction, width, meaning):
- clk, in, 1, clock.
- rst, in, 1, synchronous active-high reset.
- start, in, 1, single-cycle frame request.
- base_addr, in, A_WIDTH, address of first pixel.
- img_w, in, 11, pixels per row.
- img_h, in, 11, rows.
- busy, out, 1, frame in progress.
- done, out, 1, one-cycle frame-complete pulse.
- ren, out, 1, DRAM read enable.
- raddr, out, A_WIDTH, DRAM read address.
- rdata, in, D_WIDTH, DRAM read data, valid 1 cycle after ren.
- out_valid, out, 1, pixel available.
- out_ready, in, 1, consumer accepts pixel.
- out_data, out, D_WIDTH, pixel.
- out_eol, out, 1, pixel is last of row.
- out_last, out, 1, pixel is last of frame.

Function
REQ-006 FSM SHALL have states IDLE, RUN, DRAIN.
REQ-007 IDLE -> RUN SHALL occur when start=1 and img_w!=0 and img_h!=0, latching base_addr, img_w and img_h.
REQ-008 When start=1 and img_w=0 or img_h=0, the block SHALL stay in IDLE and pulse done the next cycle, issuing no reads.
REQ-009 start SHALL be ignored while busy=1.
REQ-010 busy SHALL be 1 in RUN and DRAIN, and 0 otherwise.
REQ-011 ren SHALL be 1 in a cycle iff state=RUN and (fifo_count + inflight) < FIFO_DEPTH.
- inflight = registered copy of the previous cycle's ren.
REQ-012 raddr SHALL start at base_addr, increment by 1 after each cycle with ren=1, and wrap modulo 2^A_WIDTH.
REQ-013 Column/row counters SHALL advance with each issued read.
- The eol flag SHALL be set on column img_w-1.
- The last flag SHALL be set on column img_w-1 of row img_h-1.
- Flags SHALL travel with the read into the FIFO.
REQ-014 After the read with last=1 is issued, the FSM SHALL go RUN -> DRAIN.
REQ-015 When inflight=1, {rdata, eol, last} SHALL be pushed into the FIFO at the end of that cycle.
REQ-016 out_valid SHALL equal FIFO not-empty.
- out_data, out_eol and out_last SHALL be the FIFO head.
- These outputs SHALL remain stable while out_valid=1 and out_ready=0.
REQ-017 A pop SHALL occur iff out_valid and out_ready; simultaneous push and pop SHALL leave fifo_count unchanged.
REQ-018 The FIFO SHALL never overflow, which REQ-011 guarantees.
REQ-019 DRAIN -> IDLE SHALL occur in the cycle the pixel with out_last=1 is popped.
- done SHALL be 1 for exactly the following cycle.
REQ-020 Throughput with out_ready held 1 SHALL be 1 pixel/cycle.
- Latency SHALL be: start sampled at edge E -> first ren in cycle E+1 -> first out_valid in cycle E+3.

Reset
REQ-021 On rst=1 at a clock edge, the following SHALL hold:
- State=IDLE.
- busy, done, ren, out_valid, out_eol, out_last, inflight = 0.
- raddr, out_data = 0.
- FIFO emptied; counters cleared.
REQ-022 Reset mid-frame SHALL abort the frame.
- rdata returning in the cycle after reset SHALL NOT be pushed.
- No done pulse SHALL be generated for the aborted frame.

Verification
REQ-023 Bench SHALL cover: base 0x00000, w=4, h=2, out_ready=1 -> ren high 8 consecutive cycles with raddr 0..7; 8 pixels out contiguously; out_eol on pixels 3 and 7; out_last on pixel 7; done pulse 1 cycle after pixel 7 accepted.
REQ-024 Bench SHALL cover: w=8, h=1, out_ready=0 -> exactly 4 ren cycles (raddr base..base+3), then ren=0; out_data holds pixel 0. Raising out_ready -> reads resume 1 per pop; all 8 pixels delivered in order.
REQ-025 Bench SHALL cover: base 0xFFFFE, w=4, h=1 -> raddr sequence 0xFFFFE, 0xFFFFF, 0x00000, 0x00001.
REQ-026 Bench SHALL cover: start with w=0, h=5 -> no ren; busy stays 0; done=1 the next cycle.
REQ-027 Bench SHALL cover: rst asserted 3 cycles into a w=16, h=16 frame -> next cycle ren=0, out_valid=0, busy=0; no push from in-flight rdata; a new start afterwards begins again at its base_addr.
REQ-028 Bench SHALL cover: start pulsed while busy=1 -> ignored; the current frame completes unchanged.
